// File: rtl/uart_pkg.sv
// Shared definitions for the APB console UART: register map, STATUS bit
// positions, the common bit-level FSM state type and small helpers.
package uart_pkg;

    localparam logic [9:0] REG_STATUS  = 10'h000;
    localparam logic [9:0] REG_CLKDIV  = 10'h004;
    localparam logic [9:0] REG_TXDATA  = 10'h008;
    localparam logic [9:0] REG_RXDATA  = 10'h00C;
    localparam logic [9:0] REG_IRQ_EN  = 10'h010;
    localparam logic [9:0] REG_IRQ_CLR = 10'h014;

    localparam int ST_RX_NONEMPTY = 0;
    localparam int ST_TX_FULL     = 1;
    localparam int ST_TX_EMPTY    = 2;
    localparam int ST_RX_OVERFLOW = 3;
    localparam int ST_TX_OVERFLOW = 4;
    localparam int ST_FRAMING_ERR = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Divisors below 4 leave no room for the mid-bit RX sample, so clamp them.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div < 16'd4) ? 16'd4 : div;
    endfunction

    function automatic logic [7:0] sat_count(input logic [8:0] cnt);
        return cnt[8] ? 8'hFF : cnt[7:0];
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Single-clock byte FIFO with occupancy count; pushes into a full FIFO are
// dropped and the head reads as zero while empty.
module uart_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [7:0]             wr_data,
    output logic [7:0]             rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/apb_uart_console.sv
// APB-attached 8N1 console UART: register file, TX/RX byte FIFOs, bit-level
// TX and RX state machines and a registered level interrupt.
module apb_uart_console
    import uart_pkg::*;
#(
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [15:0] CLKDIV_RESET = 16'd1085
) (
    input  logic        pclk,
    input  logic        preset_n,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [9:0]  paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [15:0]   clkdiv;
    logic [5:0]    irq_en;
    logic          rx_ovf;
    logic          tx_ovf;
    logic          framing_err;
    logic [31:0]   status;
    logic [31:0]   rd_data;
    logic          addr_ok;
    logic          setup;
    logic          access;
    logic          wr_acc;
    logic          rx_pop_pend;
    logic [2:0]    sticky_clr;
    logic          unused_pwdata;

    logic          tx_push;
    logic          tx_pop;
    logic          tx_full;
    logic          tx_fifo_empty;
    logic [7:0]    tx_head;
    logic [CW-1:0] tx_count;
    uart_state_t   tx_state;
    logic [15:0]   tx_div;
    logic [15:0]   tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shreg;

    logic          rx_push;
    logic          rx_pop;
    logic          rx_full;
    logic          rx_empty;
    logic [7:0]    rx_head;
    logic [CW-1:0] rx_count;
    uart_state_t   rx_state;
    logic [15:0]   rx_div;
    logic [15:0]   rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shreg;
    logic          rx_s1;
    logic          rx_s2;
    logic          rx_prev;
    logic          rx_stop_sample;
    logic          rx_ferr;

    assign unused_pwdata = &{1'b0, pwdata[31:16]};

    uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (pclk),
        .rst_n   (preset_n),
        .push    (tx_push),
        .pop     (tx_pop),
        .wr_data (pwdata[7:0]),
        .rd_data (tx_head),
        .full    (tx_full),
        .empty   (tx_fifo_empty),
        .count   (tx_count)
    );

    uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (pclk),
        .rst_n   (preset_n),
        .push    (rx_push),
        .pop     (rx_pop),
        .wr_data (rx_shreg),
        .rd_data (rx_head),
        .full    (rx_full),
        .empty   (rx_empty),
        .count   (rx_count)
    );

    always_comb begin
        status                 = '0;
        status[ST_RX_NONEMPTY] = !rx_empty;
        status[ST_TX_FULL]     = tx_full;
        status[ST_TX_EMPTY]    = tx_fifo_empty && (tx_state == IDLE);
        status[ST_RX_OVERFLOW] = rx_ovf;
        status[ST_TX_OVERFLOW] = tx_ovf;
        status[ST_FRAMING_ERR] = framing_err;
        status[15:8]           = sat_count(9'(rx_count));
        status[23:16]          = sat_count(9'(tx_count));
    end

    always_comb begin
        addr_ok = 1'b1;
        rd_data = '0;
        case (paddr)
            REG_STATUS:  rd_data = status;
            REG_CLKDIV:  rd_data = {16'b0, clkdiv};
            REG_TXDATA:  rd_data = '0;
            REG_RXDATA:  rd_data = rx_empty ? 32'b0 : {23'b0, 1'b1, rx_head};
            REG_IRQ_EN:  rd_data = {26'b0, irq_en};
            REG_IRQ_CLR: rd_data = '0;
            default:     addr_ok = 1'b0;
        endcase
    end

    assign setup      = psel && !penable;
    assign access     = psel && penable;
    assign wr_acc     = access && pwrite;
    assign tx_push    = wr_acc && (paddr == REG_TXDATA);
    assign sticky_clr = (wr_acc && (paddr == REG_IRQ_CLR)) ? pwdata[5:3] : 3'b000;
    // The pop follows what the setup cycle returned, so a byte that lands
    // between setup and access is never popped unseen.
    assign rx_pop     = access && !pwrite && (paddr == REG_RXDATA) && rx_pop_pend;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            pready      <= 1'b0;
            prdata      <= '0;
            pslverr     <= 1'b0;
            rx_pop_pend <= 1'b0;
        end else begin
            pready      <= setup;
            prdata      <= (setup && !pwrite) ? rd_data : 32'b0;
            pslverr     <= setup && !addr_ok;
            rx_pop_pend <= setup && !pwrite && (paddr == REG_RXDATA) && !rx_empty;
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            clkdiv      <= CLKDIV_RESET;
            irq_en      <= '0;
            rx_ovf      <= 1'b0;
            tx_ovf      <= 1'b0;
            framing_err <= 1'b0;
            irq         <= 1'b0;
        end else begin
            if (wr_acc && (paddr == REG_CLKDIV)) begin
                clkdiv <= pwdata[15:0];
            end
            if (wr_acc && (paddr == REG_IRQ_EN)) begin
                irq_en <= pwdata[5:0];
            end
            rx_ovf      <= (rx_push && rx_full) || (rx_ovf && !sticky_clr[0]);
            tx_ovf      <= (tx_push && tx_full) || (tx_ovf && !sticky_clr[1]);
            framing_err <= rx_ferr || (framing_err && !sticky_clr[2]);
            irq         <= |(status[5:0] & irq_en);
        end
    end

    // The end of a stop bit doubles as a frame start when more bytes wait.
    assign tx_pop = !tx_fifo_empty &&
                    ((tx_state == IDLE) || ((tx_state == STOP) && (tx_cnt == 16'd0)));

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            tx_state <= IDLE;
            tx_div   <= 16'd4;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shreg <= '0;
            uart_tx  <= 1'b1;
        end else if (tx_pop) begin
            tx_state <= START;
            tx_div   <= eff_div(clkdiv);
            tx_cnt   <= eff_div(clkdiv) - 16'd1;
            tx_shreg <= tx_head;
            uart_tx  <= 1'b0;
        end else begin
            case (tx_state)
                START: begin
                    if (tx_cnt == 16'd0) begin
                        tx_state <= DATA;
                        tx_cnt   <= tx_div - 16'd1;
                        tx_bit   <= 3'd0;
                        uart_tx  <= tx_shreg[0];
                        tx_shreg <= {1'b0, tx_shreg[7:1]};
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (tx_cnt == 16'd0) begin
                        tx_cnt <= tx_div - 16'd1;
                        if (tx_bit == 3'd7) begin
                            tx_state <= STOP;
                            uart_tx  <= 1'b1;
                        end else begin
                            tx_bit   <= tx_bit + 3'd1;
                            uart_tx  <= tx_shreg[0];
                            tx_shreg <= {1'b0, tx_shreg[7:1]};
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (tx_cnt == 16'd0) begin
                        tx_state <= IDLE;
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                default: begin
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

    assign rx_stop_sample = (rx_state == STOP) && (rx_cnt == 16'd0);
    assign rx_push        = rx_stop_sample && rx_s2;
    assign rx_ferr        = rx_stop_sample && !rx_s2;

    // After a framing error the line is still low, so rx_prev stays 0 and no
    // new start edge is seen until the line has returned high.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= IDLE;
            rx_div   <= 16'd4;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shreg <= '0;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            case (rx_state)
                IDLE: begin
                    if (!rx_s2 && rx_prev) begin
                        rx_state <= START;
                        rx_div   <= eff_div(clkdiv);
                        rx_cnt   <= (eff_div(clkdiv) >> 1) - 16'd1;
                    end
                end
                START: begin
                    if (rx_cnt == 16'd0) begin
                        if (!rx_s2) begin
                            rx_state <= DATA;
                            rx_cnt   <= rx_div - 16'd1;
                            rx_bit   <= 3'd0;
                        end else begin
                            rx_state <= IDLE;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (rx_cnt == 16'd0) begin
                        rx_shreg <= {rx_s2, rx_shreg[7:1]};
                        rx_cnt   <= rx_div - 16'd1;
                        if (rx_bit == 3'd7) begin
                            rx_state <= STOP;
                        end else begin
                            rx_bit <= rx_bit + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                default: begin
                    if (rx_cnt == 16'd0) begin
                        rx_state <= IDLE;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_uart_console.sv
// Directed self-checking bench for apb_uart_console: register access, TX
// framing, loopback receive, overflow/IRQ, framing error, glitch and reset.
module tb_apb_uart_console;

    localparam logic [9:0] A_STATUS  = 10'h000;
    localparam logic [9:0] A_CLKDIV  = 10'h004;
    localparam logic [9:0] A_TXDATA  = 10'h008;
    localparam logic [9:0] A_RXDATA  = 10'h00C;
    localparam logic [9:0] A_IRQ_EN  = 10'h010;
    localparam logic [9:0] A_IRQ_CLR = 10'h014;

    logic        pclk     = 1'b0;
    logic        preset_n = 1'b0;
    logic        psel     = 1'b0;
    logic        penable  = 1'b0;
    logic        pwrite   = 1'b0;
    logic [9:0]  paddr    = '0;
    logic [31:0] pwdata   = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        uart_tx;
    logic        irq;
    logic        uart_rx;
    logic        rx_drive = 1'b1;
    logic        loopback = 1'b0;

    int check_count = 0;
    int error_count = 0;

    assign uart_rx = loopback ? uart_tx : rx_drive;

    apb_uart_console #(.FIFO_DEPTH(16), .CLKDIV_RESET(16'd1085)) dut (
        .pclk     (pclk),
        .preset_n (preset_n),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .uart_rx  (uart_rx),
        .uart_tx  (uart_tx),
        .irq      (irq)
    );

    always #5 pclk = ~pclk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic apbRead(input logic [9:0] addr, output logic [31:0] data, output logic err, output logic rdy);
        @(negedge pclk);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = addr;
        @(negedge pclk);
        penable = 1'b1;
        data    = prdata;
        err     = pslverr;
        rdy     = pready;
        @(negedge pclk);
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    task automatic apbWrite(input logic [9:0] addr, input logic [31:0] data, output logic err);
        @(negedge pclk);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = addr;
        pwdata  = data;
        @(negedge pclk);
        penable = 1'b1;
        err     = pslverr;
        @(negedge pclk);
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    task automatic readReg(input logic [9:0] addr, output logic [31:0] data);
        logic err;
        logic rdy;
        apbRead(addr, data, err, rdy);
    endtask

    task automatic writeReg(input logic [9:0] addr, input logic [31:0] data);
        logic err;
        apbWrite(addr, data, err);
    endtask

    task automatic waitTxFall(output int cycles);
        cycles = 0;
        while (uart_tx === 1'b1 && cycles < 40) begin
            @(negedge pclk);
            cycles++;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input int div);
        logic [9:0] frame;
        frame = {stop_bit, data, 1'b0};
        for (int b = 0; b < 10; b++) begin
            rx_drive = frame[b];
            repeat (div) @(negedge pclk);
        end
        rx_drive = 1'b1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rdata;
        logic        err;
        logic        rdy;
        logic [9:0]  frame;
        int          cycles;
        int          low;
        int          bad;

        repeat (3) @(negedge pclk);
        checkOutput("reset_uart_tx", 32'(uart_tx), 32'h1);
        checkOutput("reset_irq", 32'(irq), 32'h0);
        checkOutput("reset_pready", 32'(pready), 32'h0);
        checkOutput("reset_prdata", prdata, 32'h0);
        preset_n = 1'b1;

        readReg(A_STATUS, rdata);
        checkOutput("status_after_reset", rdata, 32'h0000_0004);
        readReg(A_CLKDIV, rdata);
        checkOutput("clkdiv_reset", rdata, 32'd1085);
        readReg(A_IRQ_EN, rdata);
        checkOutput("irq_en_reset", rdata, 32'h0);

        apbRead(10'h020, rdata, err, rdy);
        checkOutput("bad_read_pslverr", 32'(err), 32'h1);
        checkOutput("bad_read_pready", 32'(rdy), 32'h1);
        checkOutput("bad_read_prdata", rdata, 32'h0);
        apbWrite(10'h018, 32'hFFFF_FFFF, err);
        checkOutput("bad_write_pslverr", 32'(err), 32'h1);
        apbRead(A_STATUS, rdata, err, rdy);
        checkOutput("good_read_pslverr", 32'(err), 32'h0);

        // A divisor of 2 reads back as written but runs as 4: 0xFF has only
        // the start bit low.
        writeReg(A_CLKDIV, 32'd2);
        readReg(A_CLKDIV, rdata);
        checkOutput("clkdiv_small_readback", rdata, 32'd2);
        writeReg(A_TXDATA, 32'h0000_00FF);
        waitTxFall(cycles);
        checkOutput("tx_latency_div2", 32'(cycles), 32'd1);
        low = 0;
        while (uart_tx === 1'b0 && low < 100) begin
            low++;
            @(negedge pclk);
        end
        checkOutput("tx_start_len_div2", 32'(low), 32'd4);
        repeat (60) @(negedge pclk);

        writeReg(A_CLKDIV, 32'd16);
        writeReg(A_TXDATA, 32'h0000_0055);
        waitTxFall(cycles);
        checkOutput("tx_latency", 32'(cycles), 32'd1);
        frame = {1'b1, 8'h55, 1'b0};
        bad = 0;
        for (int k = 0; k < 160; k++) begin
            if (uart_tx !== frame[k / 16]) bad++;
            @(negedge pclk);
        end
        checkOutput("tx_frame_bad_cycles", 32'(bad), 32'd0);
        checkOutput("tx_idle_after_frame", 32'(uart_tx), 32'h1);
        readReg(A_STATUS, rdata);
        checkOutput("status_tx_done", rdata, 32'h0000_0004);

        writeReg(A_CLKDIV, 32'd8);
        loopback = 1'b1;
        writeReg(A_TXDATA, 32'h0000_00A5);
        writeReg(A_TXDATA, 32'h0000_003C);
        repeat (220) @(negedge pclk);
        readReg(A_STATUS, rdata);
        checkOutput("status_loopback", rdata, 32'h0000_0205);
        readReg(A_RXDATA, rdata);
        checkOutput("rxdata_first", rdata, 32'h0000_01A5);
        readReg(A_RXDATA, rdata);
        checkOutput("rxdata_second", rdata, 32'h0000_013C);
        readReg(A_RXDATA, rdata);
        checkOutput("rxdata_empty", rdata, 32'h0000_0000);
        readReg(A_STATUS, rdata);
        checkOutput("status_rx_drained", rdata, 32'h0000_0004);
        loopback = 1'b0;

        // The first byte moves straight into the shifter, so 18 writes are
        // needed for 16 queued plus one dropped.
        writeReg(A_CLKDIV, 32'd1000);
        for (int i = 0; i < 18; i++) begin
            writeReg(A_TXDATA, 32'(i * 16));
        end
        readReg(A_STATUS, rdata);
        checkOutput("status_tx_overflow", rdata, 32'h0010_0012);
        writeReg(A_IRQ_EN, 32'h10);
        checkOutput("irq_before_lag", 32'(irq), 32'h0);
        @(negedge pclk);
        checkOutput("irq_asserted", 32'(irq), 32'h1);
        writeReg(A_IRQ_CLR, 32'h10);
        checkOutput("irq_clear_lag", 32'(irq), 32'h1);
        @(negedge pclk);
        checkOutput("irq_cleared", 32'(irq), 32'h0);
        readReg(A_STATUS, rdata);
        checkOutput("status_ovf_cleared", rdata, 32'h0010_0002);

        checkOutput("tx_low_mid_frame", 32'(uart_tx), 32'h0);
        #2;
        preset_n = 1'b0;
        #1;
        checkOutput("tx_async_reset", 32'(uart_tx), 32'h1);
        checkOutput("irq_async_reset", 32'(irq), 32'h0);
        repeat (2) @(negedge pclk);
        preset_n = 1'b1;
        readReg(A_STATUS, rdata);
        checkOutput("status_after_midframe_reset", rdata, 32'h0000_0004);
        readReg(A_IRQ_EN, rdata);
        checkOutput("irq_en_after_reset", rdata, 32'h0);
        readReg(A_CLKDIV, rdata);
        checkOutput("clkdiv_after_reset", rdata, 32'd1085);

        writeReg(A_CLKDIV, 32'd16);
        applyStimulus(8'h5A, 1'b0, 16);
        repeat (20) @(negedge pclk);
        readReg(A_STATUS, rdata);
        checkOutput("status_framing_err", rdata, 32'h0000_0024);
        applyStimulus(8'h7E, 1'b1, 16);
        repeat (10) @(negedge pclk);
        readReg(A_STATUS, rdata);
        checkOutput("status_after_good_frame", rdata, 32'h0000_0125);
        readReg(A_RXDATA, rdata);
        checkOutput("rxdata_7e", rdata, 32'h0000_017E);
        writeReg(A_IRQ_CLR, 32'h20);
        readReg(A_STATUS, rdata);
        checkOutput("status_framing_cleared", rdata, 32'h0000_0004);

        rx_drive = 1'b0;
        repeat (3) @(negedge pclk);
        rx_drive = 1'b1;
        repeat (40) @(negedge pclk);
        readReg(A_STATUS, rdata);
        checkOutput("status_after_glitch", rdata, 32'h0000_0004);
        applyStimulus(8'hC3, 1'b1, 16);
        repeat (10) @(negedge pclk);
        readReg(A_RXDATA, rdata);
        checkOutput("rxdata_after_glitch", rdata, 32'h0000_01C3);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
